// File: rtl/word_uart_tx_if.sv
// word_uart_tx_if: word handshake and serial line status for word_uart_tx.
// The master supplies 32-bit words and the slave serializes them.
`default_nettype none

interface word_uart_tx_if;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_out;
  logic        tx_busy;
  logic        tx_done;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx_out, tx_busy, tx_done
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx_out, tx_busy, tx_done
  );
endinterface

`default_nettype wire

// File: rtl/word_uart_tx.sv
// word_uart_tx: sends a 32-bit word as four back-to-back 8N1 UART frames.
// Revision 1.0
`default_nettype none

module word_uart_tx #(
  parameter int CLKS_PER_BIT   = 868,
  parameter bit MSB_BYTE_FIRST = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  word_uart_tx_if.slave  bus
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [BAUD_W-1:0] baud, baud_nxt;
  logic [2:0]        bit_idx, bit_nxt;
  logic [1:0]        byte_idx, byte_nxt;
  logic [31:0]       hold, hold_nxt;
  logic              line, line_nxt;
  logic              done, done_nxt;
  logic              baud_end;
  logic [1:0]        byte_sel;
  logic [7:0]        cur_byte;

  assign baud_end = (baud == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      hold     <= '0;
      line     <= 1'b1;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud     <= baud_nxt;
      bit_idx  <= bit_nxt;
      byte_idx <= byte_nxt;
      hold     <= hold_nxt;
      line     <= line_nxt;
      done     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud;
    bit_nxt   = bit_idx;
    byte_nxt  = byte_idx;
    hold_nxt  = hold;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.tx_valid) begin
          hold_nxt  = bus.tx_data;
          byte_nxt  = 2'd0;
          bit_nxt   = 3'd0;
          baud_nxt  = '0;
          state_nxt = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_nxt  = '0;
          bit_nxt   = 3'd0;
          state_nxt = DATA;
        end else begin
          baud_nxt = baud + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_nxt = '0;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_nxt = bit_idx + 3'd1;
          end
        end else begin
          baud_nxt = baud + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_nxt = '0;
          if (byte_idx == 2'd3) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            byte_nxt  = byte_idx + 2'd1;
            bit_nxt   = 3'd0;
            state_nxt = START;
          end
        end else begin
          baud_nxt = baud + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The line level is computed from next-state values so tx_out itself is a flop.
  always_comb begin
    byte_sel = MSB_BYTE_FIRST ? (2'd3 - byte_nxt) : byte_nxt;
    case (byte_sel)
      2'd0:    cur_byte = hold_nxt[7:0];
      2'd1:    cur_byte = hold_nxt[15:8];
      2'd2:    cur_byte = hold_nxt[23:16];
      default: cur_byte = hold_nxt[31:24];
    endcase
    case (state_nxt)
      START:   line_nxt = 1'b0;
      DATA:    line_nxt = cur_byte[bit_nxt];
      default: line_nxt = 1'b1;
    endcase
  end

  assign bus.tx_ready = (state == IDLE) && !reset;
  assign bus.tx_busy  = (state != IDLE);
  assign bus.tx_out   = line;
  assign bus.tx_done  = done;

endmodule

`default_nettype wire

// File: tb/tb_word_uart_tx.sv
// tb_word_uart_tx: directed vectors for word_uart_tx with three parameter sets.
`default_nettype none

module tb_word_uart_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data = '0;
  logic        valid = 1'b0;
  int          sel = 0;
  int          total = 0;
  int          bad = 0;

  logic m_out, m_ready, m_busy, m_done;

  word_uart_tx_if if0 ();
  word_uart_tx_if if1 ();
  word_uart_tx_if if2 ();

  assign if0.tx_data  = data;
  assign if1.tx_data  = data;
  assign if2.tx_data  = data;
  assign if0.tx_valid = valid && (sel == 0);
  assign if1.tx_valid = valid && (sel == 1);
  assign if2.tx_valid = valid && (sel == 2);

  word_uart_tx #(.CLKS_PER_BIT(4), .MSB_BYTE_FIRST(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  word_uart_tx #(.CLKS_PER_BIT(4), .MSB_BYTE_FIRST(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  word_uart_tx #(.CLKS_PER_BIT(2), .MSB_BYTE_FIRST(1'b0)) dut2 (.clk(clk), .reset(reset), .bus(if2));

  always #5 clk = ~clk;

  always_comb begin
    m_out = if0.tx_out; m_ready = if0.tx_ready; m_busy = if0.tx_busy; m_done = if0.tx_done;
    case (sel)
      1: begin m_out = if1.tx_out; m_ready = if1.tx_ready; m_busy = if1.tx_busy; m_done = if1.tx_done; end
      2: begin m_out = if2.tx_out; m_ready = if2.tx_ready; m_busy = if2.tx_busy; m_done = if2.tx_done; end
      default: ;
    endcase
  end

  typedef struct {
    int          unit;
    int          cpb;
    logic [31:0] word;
    logic [31:0] bytes;  // bytes in line order, first byte in [31:24]
    bit          chg;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected line level in cycle c (1-based) after acceptance.
  function automatic logic exp_bit(input logic [31:0] b, input int cpb, input int c);
    int idx, fr, pos;
    logic [7:0] by;
    idx = (c - 1) / cpb;
    fr  = idx / 10;
    pos = idx % 10;
    by  = 8'(b >> (24 - 8 * fr));
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return by[pos-1];
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!m_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", {31'd0, m_ready}, 32'd1);
  endtask

  // pre: word already presented with valid high at the current negedge.
  // keep: leave valid high with next_word so it is accepted in the done cycle.
  task automatic xfer(input int unit, input logic [31:0] word, input logic [31:0] bytes,
                      input int cpb, input bit chg, input bit pre, input bit keep,
                      input logic [31:0] next_word);
    int line_err = 0, early_done = 0, busy_err = 0;
    sel = unit;
    if (!pre) begin
      wait_ready();
      data  = word;
      valid = 1'b1;
    end
    @(posedge clk);
    for (int c = 1; c <= 40 * cpb; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (chg) data = 32'hFFFF_FFFF;
        else if (keep) data = next_word;
        else valid = 1'b0;
      end
      if (m_out !== exp_bit(bytes, cpb, c)) line_err++;
      if (m_done !== 1'b0) early_done++;
      if (m_ready !== 1'b0 || m_busy !== 1'b1) busy_err++;
    end
    check($sformatf("line_errs_%08h", word), line_err, 0);
    check("done_early", early_done, 0);
    check("ready_busy_during_word", busy_err, 0);
    @(negedge clk);
    check("done_pulse", {31'd0, m_done}, 32'd1);
    check("ready_at_done", {31'd0, m_ready}, 32'd1);
    check("idle_cycle_high", {31'd0, m_out}, 32'd1);
    if (!keep) begin
      valid = 1'b0;
      @(negedge clk);
      check("done_one_cycle", {31'd0, m_done}, 32'd0);
      check("stay_idle", {31'd0, m_busy}, 32'd0);
    end
  endtask

  initial begin
    vecs[0] = '{unit: 0, cpb: 4, word: 32'h41A0_0000, bytes: 32'h0000_A041, chg: 1'b0};
    vecs[1] = '{unit: 1, cpb: 4, word: 32'h41A0_0000, bytes: 32'h41A0_0000, chg: 1'b0};
    vecs[2] = '{unit: 2, cpb: 2, word: 32'h0000_0000, bytes: 32'h0000_0000, chg: 1'b0};
    vecs[3] = '{unit: 0, cpb: 4, word: 32'h1234_5678, bytes: 32'h7856_3412, chg: 1'b1};
    vecs[4] = '{unit: 1, cpb: 4, word: 32'hDEAD_BEEF, bytes: 32'hDEAD_BEEF, chg: 1'b0};
    vecs[5] = '{unit: 2, cpb: 2, word: 32'hA5C3_0F81, bytes: 32'h810F_C3A5, chg: 1'b0};

    repeat (3) @(negedge clk);
    check("rst_out", {31'd0, if0.tx_out}, 32'd1);
    check("rst_busy", {31'd0, if0.tx_busy}, 32'd0);
    check("rst_done", {31'd0, if0.tx_done}, 32'd0);
    check("rst_ready", {31'd0, if0.tx_ready}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst0", {31'd0, if0.tx_ready}, 32'd1);
    check("ready_after_rst1", {31'd0, if1.tx_ready}, 32'd1);
    check("ready_after_rst2", {31'd0, if2.tx_ready}, 32'd1);

    for (int i = 0; i < 6; i++)
      xfer(vecs[i].unit, vecs[i].word, vecs[i].bytes, vecs[i].cpb, vecs[i].chg, 1'b0, 1'b0, 32'd0);

    // Back-to-back words with valid held high.
    xfer(0, 32'hDEAD_BEEF, 32'hEFBE_ADDE, 4, 1'b0, 1'b0, 1'b1, 32'h0000_0001);
    xfer(0, 32'h0000_0001, 32'h0100_0000, 4, 1'b0, 1'b1, 1'b0, 32'd0);

    // Reset during bit 3 of the third byte, then a fresh word.
    sel = 0;
    wait_ready();
    data  = 32'hC3C3_C3C3;
    valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 97; c++) begin
      @(negedge clk);
      if (c == 1) valid = 1'b0;
    end
    @(negedge clk);
    check("pre_abort_line", {31'd0, m_out}, {31'd0, exp_bit(32'hC3C3_C3C3, 4, 98)});
    reset = 1'b1;
    @(negedge clk);
    check("abort_out", {31'd0, m_out}, 32'd1);
    check("abort_busy", {31'd0, m_busy}, 32'd0);
    check("abort_ready_in_rst", {31'd0, m_ready}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready_after", {31'd0, m_ready}, 32'd1);
    begin
      int dn = 0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (m_done) dn++;
      end
      check("abort_no_done", dn, 0);
    end
    xfer(0, 32'h41A0_0000, 32'h0000_A041, 4, 1'b0, 1'b0, 1'b0, 32'd0);

    // Reset wins over a simultaneous valid.
    sel   = 1;
    data  = 32'h5555_AAAA;
    valid = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    valid = 1'b0;
    check("rst_prio_busy", {31'd0, m_busy}, 32'd0);
    @(negedge clk);
    check("rst_prio_idle", {31'd0, m_busy}, 32'd0);
    check("rst_prio_out", {31'd0, m_out}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
